simon_engine: RTL and testbench
===============================

# simon_engine

Parametrised Simon game controller, successor to the fixed 4-colour, 10-step game FSM. It generates a fresh random sequence per game into the external sequence memory and replays it with timed on/off LED gaps. It checks player input with an optional response timeout, reports a score, and signals a win when the full sequence is reproduced. It sits between the random source, the sequence memory, the button decoder and the board LEDs.

## Interface
Derived widths: CW = max(1, $clog2(NUM_COLORS)); AW = max(1, $clog2(MAX_LEN)); TW = timer width sized for max(ON_TICKS, OFF_TICKS, TIMEOUT_TICKS).

Parameters:
- NUM_COLORS, 4: number of buttons/LEDs; power of two, ≥2.
- MAX_LEN, 10: sequence length needed to win; ≥1.
- ON_TICKS, 1: ticks each step's LED is lit; ≥1.
- OFF_TICKS, 1: dark ticks after each step; ≥1.
- TIMEOUT_TICKS, 8: max ticks waiting for a press; 0 disables the timeout.

Ports:
- clk_tick  in  1  game tick clock (~1 Hz).
- reset  in  1  asynchronous, active-high.
- rnd_val  in  CW  random colour from the random source.
- seq_val  in  CW  sequence memory read data; combinational from rd_addr, zero latency.
- btn_valid  in  1  one-tick press strobe from the button decoder.
- btn_val  in  CW  pressed colour, valid with btn_valid.
- write_en  out  1  sequence memory write strobe.
- wr_addr  out  AW  write address.
- wr_data  out  CW  write data.
- rd_addr  out  AW  read address.
- rnd_enable  out  1  advances the random source.
- led  out  NUM_COLORS  one-hot colour display.
- error_led  out  1  loss indicator.
- win_led  out  1  win indicator.
- score  out  AW+1  rounds completed in the current game.

## Operation
- States: INIT, SHOW_ON, SHOW_OFF, WAIT, CHECK, WIN, ERROR.
- Reset values: state INIT; all counters 0; write_en, rnd_enable, error_led, win_led, score, wr_addr, wr_data, rd_addr all 0.
- write_en and rnd_enable default to 0 on every tick unless asserted below.
- led = (1 << seq_val) while state==SHOW_ON; otherwise 0. It is decoded from the state register.
- INIT:
  - While init_idx < MAX_LEN: write_en=1, rnd_enable=1, wr_addr=init_idx, wr_data=rnd_val, init_idx++.
  - Next tick: round_len=1, play_idx=0, rd_addr=0, timer=0, go to SHOW_ON.
- SHOW_ON: timer counts. At timer==ON_TICKS-1: timer=0, go to SHOW_OFF.
- SHOW_OFF: timer counts. At timer==OFF_TICKS-1: timer=0, then:
  - If play_idx+1 < round_len: play_idx++, rd_addr=play_idx+1, go to SHOW_ON.
  - Else: input_idx=0, rd_addr=0, go to WAIT.
- WAIT:
  - btn_valid: latch btn_val, go to CHECK.
  - No press, TIMEOUT_TICKS≠0, and timer==TIMEOUT_TICKS-1: error_led=1, go to ERROR.
  - Otherwise timer++.
- CHECK, one tick, compares the latched value with seq_val:
  - Mismatch: error_led=1, go to ERROR.
  - Match with input_idx+1 < round_len: input_idx++, rd_addr=input_idx+1, timer=0, go to WAIT.
  - Match with input_idx+1 == round_len: score=round_len. If round_len==MAX_LEN: win_led=1, go to WIN. Else: round_len++, play_idx=0, rd_addr=0, timer=0, go to SHOW_ON.
- WIN / ERROR: hold all indicators until btn_valid. Then error_led=0, win_led=0, score=0, init_idx=0, go to INIT. A new sequence is generated for every game.
- btn_valid in INIT, SHOW_ON, SHOW_OFF and CHECK is ignored and dropped.
- Arithmetic: round_len, score and input_idx are AW+1 bits, so MAX_LEN is representable. rd_addr/wr_addr are the low AW bits. No wrap is possible because round_len never exceeds MAX_LEN.

## Timing
- All registers update on posedge clk_tick; reset acts immediately without a clock.
- INIT lasts MAX_LEN+1 ticks; rnd_enable pulses on exactly MAX_LEN ticks.
- Each displayed step takes ON_TICKS+OFF_TICKS ticks. Replay of round r takes r·(ON_TICKS+OFF_TICKS) ticks.
- Press-to-verdict latency: WAIT→CHECK on the tick btn_valid is sampled. The verdict (error_led, score, or next state) is registered on the following tick.
- Timeout fires TIMEOUT_TICKS ticks after WAIT entry. The timer restarts on every WAIT entry.
- A btn_valid on the same tick the timeout expires counts as a press; the press wins.
- A reset asserted mid-operation aborts any in-progress write. The full sequence is regenerated afterwards.

## Test plan
Common configuration for scenarios 1–5: NUM_COLORS=4, MAX_LEN=4, ON_TICKS=2, OFF_TICKS=1, TIMEOUT_TICKS=5; rnd_val driven 2,0,3,1.
1. Release reset, then observe INIT → write_en on 4 ticks with wr_addr 0..3 and wr_data 2,0,3,1; rnd_enable on 4 ticks; SHOW_ON on tick 5.
2. Round 1 replay → led=4'b0100 for 2 ticks, 0 for 1 tick, then WAIT with rd_addr=0.
3. Correct presses every round → score steps 1,2,3,4; win_led=1 after the 4th round's CHECK. Next press → INIT with score=0 and win_led=0.
4. Round 2, press 2 then press 1 → error_led=1 the tick after CHECK; score stays 1. Press again → INIT.
5. WAIT with no press for 5 ticks → error_led=1. A press on exactly the 5th tick → CHECK, no error.
6. NUM_COLORS=8, MAX_LEN=3: btn_val=7 matching → accepted. Async reset during SHOW_ON → led, score and write_en are 0 immediately, state INIT.

Source files
------------

// File: rtl/simon_engine_if.sv
// simon_engine_if: connections between the Simon engine and its random source, sequence memory, buttons and LEDs
interface simon_engine_if #(
   parameter int NUM_COLORS = 4,
   parameter int MAX_LEN    = 10
);
   localparam int CW = NUM_COLORS > 2 ? $clog2(NUM_COLORS) : 1;
   localparam int AW = MAX_LEN > 2 ? $clog2(MAX_LEN) : 1;
   logic [CW-1:0]         rnd_val;
   logic [CW-1:0]         seq_val;
   logic                  btn_valid;
   logic [CW-1:0]         btn_val;
   logic                  write_en;
   logic [AW-1:0]         wr_addr;
   logic [CW-1:0]         wr_data;
   logic [AW-1:0]         rd_addr;
   logic                  rnd_enable;
   logic [NUM_COLORS-1:0] led;
   logic                  error_led;
   logic                  win_led;
   logic [AW:0]           score;
   modport master (
      input  rnd_val, seq_val, btn_valid, btn_val,
      output write_en, wr_addr, wr_data, rd_addr, rnd_enable, led, error_led, win_led, score
   );
   modport slave (
      output rnd_val, seq_val, btn_valid, btn_val,
      input  write_en, wr_addr, wr_data, rd_addr, rnd_enable, led, error_led, win_led, score
   );
endinterface

// File: rtl/simon_engine.sv
// simon_engine: Simon game controller that generates, replays and checks a random colour sequence
module simon_engine #(
   parameter int NUM_COLORS    = 4,
   parameter int MAX_LEN       = 10,
   parameter int ON_TICKS      = 1,
   parameter int OFF_TICKS     = 1,
   parameter int TIMEOUT_TICKS = 8
) (
   input logic clk_tick,
   input logic reset,
   simon_engine_if.master bus
);
   localparam int CW   = NUM_COLORS > 2 ? $clog2(NUM_COLORS) : 1;
   localparam int AW   = MAX_LEN > 2 ? $clog2(MAX_LEN) : 1;
   localparam int TMAX = ON_TICKS > OFF_TICKS ? (ON_TICKS > TIMEOUT_TICKS ? ON_TICKS : TIMEOUT_TICKS)
                                              : (OFF_TICKS > TIMEOUT_TICKS ? OFF_TICKS : TIMEOUT_TICKS);
   localparam int TW   = TMAX > 1 ? $clog2(TMAX) : 1;
   typedef logic [AW:0] idx_t;
   typedef enum logic [2:0] {S_INIT, S_SHOW_ON, S_SHOW_OFF, S_WAIT, S_CHECK, S_WIN, S_ERROR} state_t;
   localparam idx_t LEN = idx_t'(MAX_LEN);
   state_t        state_q, state_d;
   idx_t          init_idx_q, init_idx_d;
   idx_t          round_len_q, round_len_d;
   idx_t          play_idx_q, play_idx_d;
   idx_t          input_idx_q, input_idx_d;
   idx_t          score_q, score_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [CW-1:0] btn_q, btn_d;
   logic [CW-1:0] wr_data_q, wr_data_d;
   logic [AW-1:0] wr_addr_q, wr_addr_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          write_en_q, write_en_d;
   logic          rnd_enable_q, rnd_enable_d;
   logic          error_q, error_d;
   logic          win_q, win_d;
   idx_t          play_nxt, input_nxt;
   assign play_nxt  = play_idx_q + idx_t'(1);
   assign input_nxt = input_idx_q + idx_t'(1);
   // state and datapath registers, cleared asynchronously so a reset aborts any write at once
   always_ff @(posedge clk_tick or posedge reset) begin
      if (reset) begin
         state_q      <= S_INIT;
         init_idx_q   <= '0;
         round_len_q  <= '0;
         play_idx_q   <= '0;
         input_idx_q  <= '0;
         score_q      <= '0;
         timer_q      <= '0;
         btn_q        <= '0;
         wr_data_q    <= '0;
         wr_addr_q    <= '0;
         rd_addr_q    <= '0;
         write_en_q   <= 1'b0;
         rnd_enable_q <= 1'b0;
         error_q      <= 1'b0;
         win_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         init_idx_q   <= init_idx_d;
         round_len_q  <= round_len_d;
         play_idx_q   <= play_idx_d;
         input_idx_q  <= input_idx_d;
         score_q      <= score_d;
         timer_q      <= timer_d;
         btn_q        <= btn_d;
         wr_data_q    <= wr_data_d;
         wr_addr_q    <= wr_addr_d;
         rd_addr_q    <= rd_addr_d;
         write_en_q   <= write_en_d;
         rnd_enable_q <= rnd_enable_d;
         error_q      <= error_d;
         win_q        <= win_d;
      end
   end
   // next state: fill memory, replay the round, then collect and judge presses
   always_comb begin
      state_d      = state_q;
      init_idx_d   = init_idx_q;
      round_len_d  = round_len_q;
      play_idx_d   = play_idx_q;
      input_idx_d  = input_idx_q;
      score_d      = score_q;
      timer_d      = timer_q;
      btn_d        = btn_q;
      wr_data_d    = wr_data_q;
      wr_addr_d    = wr_addr_q;
      rd_addr_d    = rd_addr_q;
      write_en_d   = 1'b0;
      rnd_enable_d = 1'b0;
      error_d      = error_q;
      win_d        = win_q;
      case (state_q)
         S_INIT: begin
            if (init_idx_q < LEN) begin
               write_en_d   = 1'b1;
               rnd_enable_d = 1'b1;
               wr_addr_d    = init_idx_q[AW-1:0];
               wr_data_d    = bus.rnd_val;
               init_idx_d   = init_idx_q + idx_t'(1);
            end else begin
               round_len_d = idx_t'(1);
               play_idx_d  = '0;
               rd_addr_d   = '0;
               timer_d     = '0;
               state_d     = S_SHOW_ON;
            end
         end
         S_SHOW_ON: begin
            timer_d = timer_q == TW'(ON_TICKS - 1) ? '0 : timer_q + TW'(1);
            state_d = timer_q == TW'(ON_TICKS - 1) ? S_SHOW_OFF : S_SHOW_ON;
         end
         S_SHOW_OFF: begin
            timer_d = timer_q + TW'(1);
            if (timer_q == TW'(OFF_TICKS - 1)) begin
               timer_d = '0;
               if (play_nxt < round_len_q) begin
                  play_idx_d = play_nxt;
                  rd_addr_d  = play_nxt[AW-1:0];
                  state_d    = S_SHOW_ON;
               end else begin
                  input_idx_d = '0;
                  rd_addr_d   = '0;
                  state_d     = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (bus.btn_valid) begin
               btn_d   = bus.btn_val;
               state_d = S_CHECK;
            end else if (TIMEOUT_TICKS != 0 && timer_q == TW'(TIMEOUT_TICKS - 1)) begin
               error_d = 1'b1;
               state_d = S_ERROR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_CHECK: begin
            if (btn_q != bus.seq_val) begin
               error_d = 1'b1;
               state_d = S_ERROR;
            end else if (input_nxt < round_len_q) begin
               input_idx_d = input_nxt;
               rd_addr_d   = input_nxt[AW-1:0];
               timer_d     = '0;
               state_d     = S_WAIT;
            end else begin
               score_d = round_len_q;
               if (round_len_q == LEN) begin
                  win_d   = 1'b1;
                  state_d = S_WIN;
               end else begin
                  round_len_d = round_len_q + idx_t'(1);
                  play_idx_d  = '0;
                  rd_addr_d   = '0;
                  timer_d     = '0;
                  state_d     = S_SHOW_ON;
               end
            end
         end
         S_WIN, S_ERROR: begin
            if (bus.btn_valid) begin
               error_d    = 1'b0;
               win_d      = 1'b0;
               score_d    = '0;
               init_idx_d = '0;
               state_d    = S_INIT;
            end
         end
         default: state_d = S_INIT;
      endcase
   end
   // outputs: registered strobes and indicators, LED decoded from the state register
   always_comb begin
      bus.led        = state_q == S_SHOW_ON ? NUM_COLORS'(1) << bus.seq_val : '0;
      bus.write_en   = write_en_q;
      bus.wr_addr    = wr_addr_q;
      bus.wr_data    = wr_data_q;
      bus.rd_addr    = rd_addr_q;
      bus.rnd_enable = rnd_enable_q;
      bus.error_led  = error_q;
      bus.win_led    = win_q;
      bus.score      = score_q;
   end
endmodule

// File: tb/tb_simon_engine.sv
// tb_simon_engine: directed checks of the Simon engine with a memory and random-source stub per instance
module tb_simon_engine;
   logic clk_tick = 1'b0;
   logic reset_a = 1'b1;
   logic reset_b = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   always #5 clk_tick = ~clk_tick;
   simon_engine_if #(.NUM_COLORS(4), .MAX_LEN(4)) a_if ();
   simon_engine_if #(.NUM_COLORS(8), .MAX_LEN(3)) b_if ();
   simon_engine #(.NUM_COLORS(4), .MAX_LEN(4), .ON_TICKS(2), .OFF_TICKS(1), .TIMEOUT_TICKS(5)) u_a (
      .clk_tick(clk_tick), .reset(reset_a), .bus(a_if.master));
   simon_engine #(.NUM_COLORS(8), .MAX_LEN(3), .ON_TICKS(1), .OFF_TICKS(1), .TIMEOUT_TICKS(8)) u_b (
      .clk_tick(clk_tick), .reset(reset_b), .bus(b_if.master));
   logic [1:0] tbl_a [4] = '{2'd2, 2'd0, 2'd3, 2'd1};
   logic [2:0] tbl_b [3] = '{3'd7, 3'd3, 3'd5};
   logic [1:0] mem_a [4];
   logic [2:0] mem_b [4];
   assign a_if.rnd_val = a_if.write_en ? tbl_a[(a_if.wr_addr + 1) % 4] : tbl_a[0];
   assign b_if.rnd_val = b_if.write_en ? tbl_b[(b_if.wr_addr + 1) % 3] : tbl_b[0];
   assign a_if.seq_val = mem_a[a_if.rd_addr];
   assign b_if.seq_val = mem_b[b_if.rd_addr];
   always @(posedge clk_tick) begin
      if (a_if.write_en) mem_a[a_if.wr_addr] <= a_if.wr_data;
      if (b_if.write_en) mem_b[b_if.wr_addr] <= b_if.wr_data;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   task automatic tick();
      @(posedge clk_tick);
      #1;
   endtask
   task automatic init_a();
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("init_we", a_if.write_en, 1);
         chk("init_addr", a_if.wr_addr, k);
         chk("init_data", a_if.wr_data, tbl_a[k]);
         chk("init_rnd", a_if.rnd_enable, 1);
      end
      tick();
      chk("init_end_we", a_if.write_en, 0);
      chk("init_end_rnd", a_if.rnd_enable, 0);
   endtask
   task automatic replay_a(input int r, input logic noise);
      a_if.btn_valid = noise;
      a_if.btn_val   = 2'd3;
      for (int s = 0; s < r; s++) begin
         chk("show_on", a_if.led, 4'b1 << tbl_a[s]);
         chk("show_rd", a_if.rd_addr, s);
         tick();
         chk("show_on2", a_if.led, 4'b1 << tbl_a[s]);
         tick();
         chk("show_off", a_if.led, 0);
         tick();
      end
      a_if.btn_valid = 1'b0;
      chk("wait_led", a_if.led, 0);
      chk("wait_rd", a_if.rd_addr, 0);
   endtask
   task automatic press_a(input logic [1:0] c);
      a_if.btn_valid = 1'b1;
      a_if.btn_val   = c;
      tick();
      a_if.btn_valid = 1'b0;
      chk("check_err", a_if.error_led, 0);
      tick();
   endtask
   task automatic restart_a();
      a_if.btn_valid = 1'b1;
      tick();
      a_if.btn_valid = 1'b0;
      chk("restart_err", a_if.error_led, 0);
      chk("restart_win", a_if.win_led, 0);
      chk("restart_score", a_if.score, 0);
   endtask
   initial begin
      a_if.btn_valid = 1'b0;
      a_if.btn_val   = '0;
      b_if.btn_valid = 1'b0;
      b_if.btn_val   = '0;
      repeat (2) tick();
      chk("rst_we", a_if.write_en, 0);
      chk("rst_rnd", a_if.rnd_enable, 0);
      chk("rst_err", a_if.error_led, 0);
      chk("rst_win", a_if.win_led, 0);
      chk("rst_score", a_if.score, 0);
      chk("rst_led", a_if.led, 0);
      chk("rst_rd", a_if.rd_addr, 0);
      chk("rst_wa", a_if.wr_addr, 0);
      chk("rst_wd", a_if.wr_data, 0);
      reset_a = 1'b0;
      init_a();
      for (int r = 1; r <= 4; r++) begin
         replay_a(r, 1'b0);
         for (int i = 0; i < r; i++) begin
            press_a(tbl_a[i]);
            chk("score", a_if.score, i == r - 1 ? r : r - 1);
         end
         chk("win", a_if.win_led, r == 4);
      end
      tick();
      chk("win_hold", a_if.win_led, 1);
      chk("win_score", a_if.score, 4);
      restart_a();
      init_a();
      replay_a(1, 1'b1);
      press_a(2'd2);
      chk("g2_score", a_if.score, 1);
      replay_a(2, 1'b0);
      press_a(2'd2);
      chk("g2_mid_err", a_if.error_led, 0);
      press_a(2'd1);
      chk("g2_err", a_if.error_led, 1);
      chk("g2_score_kept", a_if.score, 1);
      tick();
      chk("g2_err_hold", a_if.error_led, 1);
      restart_a();
      init_a();
      replay_a(1, 1'b0);
      repeat (4) tick();
      chk("to_early", a_if.error_led, 0);
      tick();
      chk("to_fire", a_if.error_led, 1);
      restart_a();
      init_a();
      replay_a(1, 1'b0);
      repeat (4) tick();
      press_a(2'd2);
      chk("to_press_err", a_if.error_led, 0);
      chk("to_press_score", a_if.score, 1);
      chk("to_press_led", a_if.led, 4'b0100);
      reset_a = 1'b1;
      reset_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("b_we", b_if.write_en, 1);
         chk("b_data", b_if.wr_data, tbl_b[k]);
      end
      tick();
      chk("b_show", b_if.led, 8'h80);
      tick();
      chk("b_off", b_if.led, 0);
      tick();
      b_if.btn_valid = 1'b1;
      b_if.btn_val   = 3'd7;
      tick();
      b_if.btn_valid = 1'b0;
      tick();
      chk("b_score", b_if.score, 1);
      chk("b_err", b_if.error_led, 0);
      chk("b_show2", b_if.led, 8'h80);
      #2 reset_b = 1'b1;
      #1;
      chk("b_rst_led", b_if.led, 0);
      chk("b_rst_score", b_if.score, 0);
      chk("b_rst_we", b_if.write_en, 0);
      tick();
      chk("b_rst_hold_we", b_if.write_en, 0);
      reset_b = 1'b0;
      tick();
      chk("b_regen_we", b_if.write_en, 1);
      chk("b_regen_addr", b_if.wr_addr, 0);
      chk("b_regen_data", b_if.wr_data, 7);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
